// File: rtl/shift_left2_n26.sv
// Jump-target shifter: {in, 2'b00} combinationally, plus a valid-qualified
// registered copy joined with the upper PC bits to form the jump address.
module shift_left2_n26 #(
  parameter int unsigned SIZE   = 26,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [SIZE-1:0]                                       in,
  output logic [SIZE+1:0]                                       out,
  input  logic                                                  en,
  input  logic                                                  flush,
  input  logic [((ADDR_W > SIZE+2) ? ADDR_W-SIZE-2 : 1)-1:0]    pc_hi,
  output logic [SIZE+1:0]                                       out_q,
  output logic                                                  valid_q,
  output logic [ADDR_W-1:0]                                     jump_addr
);

  localparam int unsigned HI_W = (ADDR_W > SIZE + 2) ? ADDR_W - SIZE - 2 : 0;

  generate
    if (SIZE + 2 > ADDR_W) begin : g_bad_width
      $error("shift_left2_n26: SIZE+2 must not exceed ADDR_W");
    end
  endgenerate

  assign out = {in, 2'b00};

  // flush only invalidates; the captured data is kept for inspection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (en) begin
      out_q   <= {in, 2'b00};
      valid_q <= 1'b1;
    end
  end

  generate
    if (HI_W > 0) begin : g_pc_hi
      logic [HI_W-1:0] pc_hi_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pc_hi_q <= '0;
        end else if (!flush && en) begin
          pc_hi_q <= pc_hi;
        end
      end

      assign jump_addr = {pc_hi_q, out_q};
    end else begin : g_no_pc_hi
      // pc_hi is an unused 1-bit stub here and carries no address bits
      assign jump_addr = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_shift_left2_n26.sv
// Directed bench for shift_left2_n26 at default parameters (SIZE=26, ADDR_W=32).
module tb_shift_left2_n26;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] in;
  logic [27:0] out;
  logic        en;
  logic        flush;
  logic [3:0]  pc_hi;
  logic [27:0] out_q;
  logic        valid_q;
  logic [31:0] jump_addr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  shift_left2_n26 #(.SIZE(26), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .out       (out),
    .en        (en),
    .flush     (flush),
    .pc_hi     (pc_hi),
    .out_q     (out_q),
    .valid_q   (valid_q),
    .jump_addr (jump_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; in = '0; pc_hi = '0;
    #1;
    check("rst_out_q",   32'(out_q),     32'h0);
    check("rst_valid",   32'(valid_q),   32'h0);
    check("rst_jump",    jump_addr,      32'h0);
    check("out_zero",    32'(out),       32'h0);

    in = 26'd1; #1;
    check("out_in1",     32'(out),       32'h0000004);
    #100 in = 26'd2; #1;
    check("out_in2",     32'(out),       32'h0000008);
    #100 in = 26'd5; #1;
    check("out_in5",     32'(out),       32'h0000014);

    @(negedge clk);
    reset = 1'b0; en = 1'b1; in = 26'h3FFFFFF; pc_hi = 4'hA;
    #1;
    check("out_ones",    32'(out),       32'hFFFFFFC);
    @(posedge clk); #1;
    check("cap_out_q",   32'(out_q),     32'hFFFFFFC);
    check("cap_valid",   32'(valid_q),   32'h1);
    check("cap_jump",    jump_addr,      32'hAFFFFFFC);

    @(negedge clk);
    en = 1'b0; in = 26'h0000123; pc_hi = 4'h3;
    #1;
    check("hold_out",    32'(out),       32'h000048C);
    repeat (3) @(posedge clk);
    #1;
    check("hold_out_q",  32'(out_q),     32'hFFFFFFC);
    check("hold_jump",   jump_addr,      32'hAFFFFFFC);
    check("hold_valid",  32'(valid_q),   32'h1);

    @(negedge clk);
    en = 1'b1; flush = 1'b1; in = 26'h0000010; pc_hi = 4'h0;
    @(posedge clk); #1;
    check("flush_valid", 32'(valid_q),   32'h0);
    check("flush_out_q", 32'(out_q),     32'hFFFFFFC);
    check("flush_jump",  jump_addr,      32'hAFFFFFFC);

    @(negedge clk);
    flush = 1'b0;
    @(posedge clk); #1;
    check("cap2_out_q",  32'(out_q),     32'h40);
    check("cap2_valid",  32'(valid_q),   32'h1);
    check("cap2_jump",   jump_addr,      32'h00000040);

    @(negedge clk);
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid",  32'(valid_q),   32'h0);
    check("arst_out_q",  32'(out_q),     32'h0);
    check("arst_jump",   jump_addr,      32'h0);

    @(negedge clk);
    en = 1'b1; in = 26'h0000002; pc_hi = 4'h5;
    @(posedge clk); #1;
    check("rsthold_valid", 32'(valid_q), 32'h0);
    check("rsthold_jump",  jump_addr,    32'h0);

    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(valid_q), 32'h0);
    check("post_rst_jump",  jump_addr,    32'h0);

    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("cap3_out_q",  32'(out_q),     32'h8);
    check("cap3_valid",  32'(valid_q),   32'h1);
    check("cap3_jump",   jump_addr,      32'h50000008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
